chain_constraint_solver: RTL and testbench

Iterative fixed-point distance-constraint solver for a chain of N particles. It holds a particle position file, is loaded over a write port, and on `start` applies per-axis maximum-separation constraints to every adjacent pair, Gauss-Seidel style, for ITER passes. It generalises the single-point up/down constraint stage to a full chain with configurable width, depth, iteration count and optional pinning of particle 0. It sits between the integrator and the renderer readout in the cloth/rope pipeline.

---
 rtl/chain_constraint_solver.sv | 194 +++++++++++++++++++
 tb/tb_chain_constraint_solver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/chain_constraint_solver.sv
// Gauss-Seidel max-separation solver for a chain of N particles held in a local position file.
// Each adjacent pair is fetched, corrected per axis and written back; the chain is swept ITER times per start.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; write port active
// S_FETCH | register p[idx] and p[idx+1]
// S_APPLY | apply per-axis correction, write both back, advance idx/pass
module chain_constraint_solver #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int N    = 8,
  parameter int ITER = 4,
  parameter int AW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_x,
  input  logic [W-1:0]  wr_y,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_x,
  output logic [W-1:0]  rd_y,
  input  logic [W-1:0]  max_d,
  input  logic          pin0,
  input  logic          start,
  output logic          busy,
  output logic          done
);

  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [AW:0]   N_EXT  = (AW+1)'(N);
  localparam logic [AW-1:0] I_LAST = AW'(N - 2);
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

  if (N < 2 || ITER < 1 || FRAC >= W) begin : g_param_check
    $error("chain_constraint_solver: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_APPLY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_b;
  logic [KW-1:0]   pass;
  logic [W-1:0]    max_d_r;
  logic            pin0_r;
  logic            done_r;
  logic            accept, pair_adv, pass_adv, finish;
  logic [W-1:0]    ax, ay, bx, by;
  logic [2*W-1:0]  res_x, res_y;
  logic            pin_pair;
  logic [W-1:0]    mem_x [N];
  logic [W-1:0]    mem_y [N];

  // Moves both ends toward each other so |pb-pa| <= lim; results stay between the inputs.
  function automatic logic [2*W-1:0] solve_axis(input logic [W-1:0] pa, input logic [W-1:0] pb,
                                                input logic [W-1:0] lim, input logic pinned);
    logic signed [W:0] d;
    logic [W:0]        mag, e, ea, eb;
    logic [W-1:0]      na, nb;
    d   = $signed({pb[W-1], pb}) - $signed({pa[W-1], pa});
    mag = d[W] ? $unsigned(-d) : $unsigned(d);
    e   = '0;
    ea  = '0;
    eb  = '0;
    na  = pa;
    nb  = pb;
    if (mag > {1'b0, lim}) begin
      e  = mag - {1'b0, lim};
      ea = pinned ? '0 : (e >> 1);
      eb = e - ea;
      if (d[W]) begin
        na = pa - W'(ea);
        nb = pb + W'(eb);
      end else begin
        na = pa + W'(ea);
        nb = pb - W'(eb);
      end
    end
    return {na, nb};
  endfunction

  assign idx_b    = idx + AW'(1);
  assign pin_pair = pin0_r && (idx == '0);
  assign res_x    = solve_axis(ax, bx, max_d_r, pin_pair);
  assign res_y    = solve_axis(ay, by, max_d_r, pin_pair);
  assign busy     = (state != S_IDLE);
  assign done     = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pair_adv  = 1'b0;
    pass_adv  = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_APPLY;
      S_APPLY: begin
        if (idx != I_LAST) begin
          pair_adv  = 1'b1;
          state_nxt = S_FETCH;
        end else if (pass != K_LAST) begin
          pass_adv  = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      pass    <= '0;
      max_d_r <= '0;
      pin0_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= finish;
      if (accept) begin
        idx     <= '0;
        pass    <= '0;
        max_d_r <= max_d;
        pin0_r  <= pin0;
      end else if (pair_adv) begin
        idx <= idx_b;
      end else if (pass_adv) begin
        idx  <= '0;
        pass <= pass + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax <= '0;
      ay <= '0;
      bx <= '0;
      by <= '0;
    end else if (state == S_FETCH) begin
      ax <= mem_x[idx];
      ay <= mem_y[idx];
      bx <= mem_x[idx_b];
      by <= mem_y[idx_b];
    end
  end

  // The write port and the solver never compete: external writes only land in S_IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        mem_x[j] <= '0;
        mem_y[j] <= '0;
      end
    end else if (state == S_APPLY) begin
      mem_x[idx]   <= res_x[2*W-1:W];
      mem_y[idx]   <= res_y[2*W-1:W];
      mem_x[idx_b] <= res_x[W-1:0];
      mem_y[idx_b] <= res_y[W-1:0];
    end else if (state == S_IDLE && wr_en && ({1'b0, wr_addr} < N_EXT)) begin
      mem_x[wr_addr] <= wr_x;
      mem_y[wr_addr] <= wr_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x <= '0;
      rd_y <= '0;
    end else if ({1'b0, rd_addr} < N_EXT) begin
      rd_x <= mem_x[rd_addr];
      rd_y <= mem_y[rd_addr];
    end else begin
      rd_x <= '0;
      rd_y <= '0;
    end
  end

endmodule

// File: tb/tb_chain_constraint_solver.sv
// Bench for chain_constraint_solver: a 2-particle/1-pass instance for the arithmetic cases and a
// 4-particle/2-pass instance for timing, busy lockout, multi-pass results and mid-solve reset.
module tb_chain_constraint_solver;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a: N=2, ITER=1
  logic         wr_en_a = 0, rd_addr_a = 0, wr_addr_a = 0, pin0_a = 0, start_a = 0;
  logic [W-1:0] wr_x_a = 0, wr_y_a = 0, max_d_a = 0;
  logic [W-1:0] rd_x_a, rd_y_a;
  logic         busy_a, done_a;

  // instance b: N=4, ITER=2
  logic         wr_en_b = 0, pin0_b = 0, start_b = 0;
  logic [1:0]   wr_addr_b = 0, rd_addr_b = 0;
  logic [W-1:0] wr_x_b = 0, wr_y_b = 0, max_d_b = 0;
  logic [W-1:0] rd_x_b, rd_y_b;
  logic         busy_b, done_b;

  chain_constraint_solver #(.W(W), .FRAC(16), .N(2), .ITER(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_x(wr_x_a), .wr_y(wr_y_a),
    .rd_addr(rd_addr_a), .rd_x(rd_x_a), .rd_y(rd_y_a), .max_d(max_d_a), .pin0(pin0_a),
    .start(start_a), .busy(busy_a), .done(done_a));

  chain_constraint_solver #(.W(W), .FRAC(16), .N(4), .ITER(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_x(wr_x_b), .wr_y(wr_y_b),
    .rd_addr(rd_addr_b), .rd_x(rd_x_b), .rd_y(rd_y_b), .max_d(max_d_b), .pin0(pin0_b),
    .start(start_b), .busy(busy_b), .done(done_b));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] mx[4], my[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: signed 64-bit arithmetic on the spec's correction rule.
  function automatic void model_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lim,
                                     input bit pin, output logic [31:0] na, output logic [31:0] nb);
    longint d, m, e, ea, eb;
    d  = longint'($signed(b)) - longint'($signed(a));
    m  = (d < 0) ? -d : d;
    na = a;
    nb = b;
    if (m > longint'({32'd0, lim})) begin
      e  = m - longint'({32'd0, lim});
      ea = pin ? 0 : e / 2;
      eb = e - ea;
      if (d > 0) begin
        na = 32'(longint'($signed(a)) + ea);
        nb = 32'(longint'($signed(b)) - eb);
      end else begin
        na = 32'(longint'($signed(a)) - ea);
        nb = 32'(longint'($signed(b)) + eb);
      end
    end
  endfunction

  function automatic void model_solve_b(input logic [31:0] lim, input bit pin);
    logic [31:0] na, nb;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) begin
        model_pair(mx[i], mx[i+1], lim, pin && i == 0, na, nb);
        mx[i] = na; mx[i+1] = nb;
        model_pair(my[i], my[i+1], lim, pin && i == 0, na, nb);
        my[i] = na; my[i+1] = nb;
      end
  endfunction

  task automatic write_a(input logic addr, input logic [31:0] x, input logic [31:0] y);
    wr_en_a = 1; wr_addr_a = addr; wr_x_a = x; wr_y_a = y;
    @(posedge clk); #1;
    wr_en_a = 0;
  endtask

  task automatic read_a(input logic addr, input logic [31:0] ex, input logic [31:0] ey, input string tag);
    rd_addr_a = addr;
    exp_q.push_back({ex, ey});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    check(tag_q.pop_front(), {rd_x_a, rd_y_a}, exp_q.pop_front());
  endtask

  task automatic write_b(input logic [1:0] addr, input logic [31:0] x, input logic [31:0] y);
    wr_en_b = 1; wr_addr_b = addr; wr_x_b = x; wr_y_b = y;
    @(posedge clk); #1;
    wr_en_b = 0;
  endtask

  task automatic read_b(input logic [1:0] addr, input logic [31:0] ex, input logic [31:0] ey, input string tag);
    rd_addr_b = addr;
    exp_q.push_back({ex, ey});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    check(tag_q.pop_front(), {rd_x_b, rd_y_b}, exp_q.pop_front());
  endtask

  // Solve on instance a; checks done arrives 2 cycles after start, exactly once.
  task automatic solve_a(input logic [31:0] lim, input logic pin, input string tag);
    int done_cnt = 0, done_at = -1;
    max_d_a = lim; pin0_a = pin; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int j = 0; j < 8; j++) begin
      if (done_a) begin done_cnt++; if (done_at < 0) done_at = j; end
      @(posedge clk); #1;
    end
    check({tag, " done_at"}, 64'(done_at), 64'd2);
    check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  // Solve on instance b with a write and a start injected while busy.
  task automatic solve_b(input logic [31:0] lim, input logic pin, input string tag);
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    max_d_b = lim; pin0_b = pin; start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    for (int j = 0; j < 30; j++) begin
      if (busy_b) busy_cnt++;
      if (done_b) begin done_cnt++; if (done_at < 0) done_at = j; end
      if (j == 3) begin
        wr_en_b = 1; start_b = 1; wr_addr_b = 2'd0; wr_x_b = 32'hDEAD_BEEF; wr_y_b = 32'h1234_5678;
        max_d_b = 32'd0;
      end else begin
        wr_en_b = 0; start_b = 0;
      end
      @(posedge clk); #1;
    end
    check({tag, " busy_cnt"}, 64'(busy_cnt), 64'd12);
    check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, " done_at"}, 64'(done_at), 64'd12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lim;
    logic [31:0] ox[4], oy[4];
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("reset busy_a", {63'd0, busy_a}, 64'd0);
    check("reset done_b", {63'd0, done_b}, 64'd0);
    read_a(1'b1, 32'd0, 32'd0, "reset mem_a p1");

    // pinned pull-up
    write_a(1'b0, 32'h000C_8000, 32'h0003_2000);
    write_a(1'b1, 32'h000C_8000, 32'h0005_0000);
    solve_a(32'h0001_0000, 1'b1, "pinned");
    read_a(1'b0, 32'h000C_8000, 32'h0003_2000, "pinned p0");
    read_a(1'b1, 32'h000C_8000, 32'h0004_2000, "pinned p1");

    // unpinned symmetric
    write_a(1'b0, 32'h000C_8000, 32'h0003_2000);
    write_a(1'b1, 32'h000C_8000, 32'h0005_0000);
    solve_a(32'h0001_0000, 1'b0, "sym");
    read_a(1'b0, 32'h000C_8000, 32'h0003_9000, "sym p0");
    read_a(1'b1, 32'h000C_8000, 32'h0004_9000, "sym p1");

    // negative direction
    write_a(1'b0, 32'h000C_8000, 32'h0005_0000);
    write_a(1'b1, 32'h000C_8000, 32'h0003_2000);
    solve_a(32'h0001_0000, 1'b0, "neg");
    read_a(1'b0, 32'h000C_8000, 32'h0004_9000, "neg p0");
    read_a(1'b1, 32'h000C_8000, 32'h0003_9000, "neg p1");

    // odd excess
    write_a(1'b0, 32'h0000_0000, 32'h0);
    write_a(1'b1, 32'h0001_0001, 32'h0);
    solve_a(32'h0001_0000, 1'b0, "odd");
    read_a(1'b0, 32'h0000_0000, 32'h0, "odd p0");
    read_a(1'b1, 32'h0001_0000, 32'h0, "odd p1");

    // extremes, no wrap
    write_a(1'b0, 32'h7FFF_0000, 32'h0);
    write_a(1'b1, 32'h8000_0000, 32'h0);
    solve_a(32'h0, 1'b0, "ext");
    read_a(1'b0, 32'hFFFF_8000, 32'h0, "ext p0");
    read_a(1'b1, 32'hFFFF_8000, 32'h0, "ext p1");

    // multi-pass random chains, pinned and unpinned
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        mx[i] = $urandom(); my[i] = $urandom();
        write_b(2'(i), mx[i], my[i]);
      end
      lim = $urandom_range(0, 32'h4000_0000);
      model_solve_b(lim, r == 0);
      solve_b(lim, r == 0, r == 0 ? "mp_pin" : "mp_free");
      for (int i = 0; i < 4; i++) read_b(2'(i), mx[i], my[i], $sformatf("mp%0d p%0d", r, i));
    end

    // chain already within max_d stays bit-identical
    for (int i = 0; i < 4; i++) begin
      ox[i] = 32'h0001_0000 * i + $urandom_range(0, 255);
      oy[i] = 32'hFFF0_0000 - 32'h0000_8000 * i;
      write_b(2'(i), ox[i], oy[i]);
    end
    solve_b(32'h0002_0000, 1'b0, "within");
    for (int i = 0; i < 4; i++) read_b(2'(i), ox[i], oy[i], $sformatf("within p%0d", i));

    // reset mid-solve
    for (int i = 0; i < 4; i++) write_b(2'(i), 32'h0010_0000 * i, 32'h0);
    max_d_b = 32'h0; pin0_b = 0; start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("rst busy_b", {63'd0, busy_b}, 64'd0);
    check("rst done_b", {63'd0, done_b}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) read_b(2'(i), 32'h0, 32'h0, $sformatf("rst clr p%0d", i));
    for (int i = 0; i < 4; i++) begin
      mx[i] = 32'h0004_0000 * i; my[i] = 32'h0 - 32'h0003_0000 * i;
      write_b(2'(i), mx[i], my[i]);
    end
    model_solve_b(32'h0001_0000, 1'b1);
    solve_b(32'h0001_0000, 1'b1, "post_rst");
    for (int i = 0; i < 4; i++) read_b(2'(i), mx[i], my[i], $sformatf("post_rst p%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
